// File: rtl/core_host.sv
// Host sequencer for a processor core: reset pulse, run until done, then stream a data-memory window out.
// Optional run-cycle timeout abort is compiled in with `define CORE_HOST_TIMEOUT_EN.
module core_host #(
    parameter logic [7:0]  BASE = 8'h00,
    parameter logic [8:0]  LEN  = 9'd64,
    parameter logic [15:0] TMO  = 16'd4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        core_reset,
    input  logic        core_done,
    output logic [7:0]  dm_addr,
    input  logic [7:0]  dm_dat,
    output logic [7:0]  out_dat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] cycles,
    output logic        timeout,
    output logic        finished
);

    typedef enum logic [2:0] {IDLE, RSTC, RUN, DUMP, FIN} state_t;

    state_t      state_q, state_d;
    logic        rc_q, rc_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] cycles_q, cycles_d;
    logic        timeout_q, timeout_d;
    logic        tmo_hit;

`ifdef CORE_HOST_TIMEOUT_EN
    // Abort decision is made in the TMO-th RUN cycle so DUMP starts with cycles == TMO.
    assign tmo_hit = ({1'b0, cycles_q} + 17'd1) >= {1'b0, TMO};
`else
    logic tmo_unused;
    assign tmo_hit    = 1'b0;
    assign tmo_unused = ^TMO;
`endif

    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        idx_d     = idx_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RSTC;
                    rc_d      = 1'b0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            RSTC: begin
                rc_d = 1'b1;
                if (rc_q) state_d = RUN;
            end
            RUN: begin
                idx_d = '0;
                if (cycles_q != '1) cycles_d = cycles_q + 16'd1;
                if (core_done) begin
                    state_d = DUMP;
                end else if (tmo_hit) begin
                    state_d   = DUMP;
                    timeout_d = 1'b1;
                end
            end
            DUMP: begin
                if (out_ready) begin
                    if ({1'b0, idx_q} == (LEN - 9'd1)) begin
                        state_d = FIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rc_q      <= 1'b0;
            idx_q     <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_q      <= rc_d;
            idx_q     <= idx_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

    assign core_reset = (state_q != RUN);
    assign busy       = (state_q != IDLE);
    assign finished   = (state_q == FIN);
    assign out_valid  = (state_q == DUMP);
    assign dm_addr    = (state_q == DUMP) ? (BASE + idx_q) : '0;
    assign out_dat    = (state_q == DUMP) ? dm_dat : '0;
    assign cycles     = cycles_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_core_host.sv
// Directed bench for core_host: two instances (BASE 00 and FE, LEN 4) share stimulus; dump bytes go through a queue scoreboard.
module tb_core_host;

    logic clk = 1'b0;
    logic reset, start, core_done, out_ready;
    logic core_reset0, out_valid0, busy0, timeout0, finished0;
    logic core_reset1, out_valid1, busy1, timeout1, finished1;
    logic [7:0] dm_addr0, dm_dat0, out_dat0, dm_addr1, dm_dat1, out_dat1;
    logic [15:0] cycles0, cycles1;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    typedef struct packed {
        logic [7:0] a0;
        logic [7:0] d0;
        logic [7:0] a1;
        logic [7:0] d1;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [7:0] a);
        return (a * 8'd7) ^ 8'h3C;
    endfunction

    assign dm_dat0 = memf(dm_addr0);
    assign dm_dat1 = memf(dm_addr1);

    core_host #(.BASE(8'h00), .LEN(9'd4), .TMO(16'd20)) u0 (
        .clk(clk), .reset(reset), .start(start), .core_reset(core_reset0),
        .core_done(core_done), .dm_addr(dm_addr0), .dm_dat(dm_dat0),
        .out_dat(out_dat0), .out_valid(out_valid0), .out_ready(out_ready),
        .busy(busy0), .cycles(cycles0), .timeout(timeout0), .finished(finished0)
    );

    core_host #(.BASE(8'hFE), .LEN(9'd4), .TMO(16'd20)) u1 (
        .clk(clk), .reset(reset), .start(start), .core_reset(core_reset1),
        .core_done(core_done), .dm_addr(dm_addr1), .dm_dat(dm_dat1),
        .out_dat(out_dat1), .out_valid(out_valid1), .out_ready(out_ready),
        .busy(busy1), .cycles(cycles1), .timeout(timeout1), .finished(finished1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        logic [7:0] b0;
        logic [7:0] b1;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            b0 = 8'h00;
            b1 = 8'hFE;
            b0 = b0 + i[7:0];
            b1 = b1 + i[7:0];
            e.a0 = b0;
            e.d0 = memf(b0);
            e.a1 = b1;
            e.d1 = memf(b1);
            sb.push_back(e);
        end
    endtask

    // rmode 0: always ready; rmode 1: ready pattern 1,0,0 repeating.
    task automatic run(input int n_run, input int rmode, input int abort_after,
                       input bit hold_start, input bit expect_tmo);
        int xfers;
        xfers = 0;
        start = 1'b1;
        core_done = !expect_tmo;
        out_ready = 1'b0;
        #1;
        chk("idle_busy", busy0, 0);
        next();
        if (!hold_start) start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            #1;
            chk("rstc_core_reset", core_reset0, 1);
            chk("rstc_busy", busy0, 1);
            chk("rstc_cycles", cycles0, 0);
            chk("rstc_timeout", timeout0, 0);
            chk("rstc_valid", out_valid0, 0);
            next();
        end
        for (int k = 1; k <= n_run; k++) begin
            core_done = (!expect_tmo && k == n_run);
            if (k == n_run) push_expected();
            #1;
            if (k <= 12 || k == n_run) begin
                chk("run_core_reset", core_reset0, 0);
                chk("run_cycles", cycles0, k - 1);
                chk("run_busy", busy0, 1);
                chk("run_valid", out_valid0, 0);
                chk("run_timeout", timeout0, 0);
            end
            next();
        end
        core_done = !expect_tmo;
        for (int c = 0; c < 64 && sb.size() > 0; c++) begin
            if (abort_after >= 0 && xfers == abort_after) begin
                reset = 1'b0;
                out_ready = 1'b1;
                next();
                reset = 1'b1;
                out_ready = 1'b0;
                #1;
                chk("abort_busy", busy0, 0);
                chk("abort_valid0", out_valid0, 0);
                chk("abort_valid1", out_valid1, 0);
                chk("abort_core_reset", core_reset0, 1);
                chk("abort_cycles", cycles0, 0);
                chk("abort_addr1", dm_addr1, 0);
                sb.delete();
                for (int j = 0; j < 3; j++) begin
                    next();
                    #1;
                    chk("abort_no_finished", finished0, 0);
                    chk("abort_idle", busy0, 0);
                end
                return;
            end
            out_ready = (rmode == 0) ? 1'b1 : (c % 3 == 0);
            #1;
            chk("dump_valid0", out_valid0, 1);
            chk("dump_valid1", out_valid1, 1);
            chk("dump_finished", finished0, 0);
            chk("dump_core_reset", core_reset0, 1);
            chk("dump_cycles", cycles0, n_run);
            chk("dump_timeout", timeout0, expect_tmo);
            chk("dump_addr0", dm_addr0, sb[0].a0);
            chk("dump_data0", out_dat0, sb[0].d0);
            chk("dump_addr1", dm_addr1, sb[0].a1);
            chk("dump_data1", out_dat1, sb[0].d1);
            if (out_ready) begin
                void'(sb.pop_front());
                xfers++;
            end
            next();
        end
        chk("dump_count", xfers, 4);
        out_ready = 1'b0;
        if (hold_start) start = 1'b0;
        #1;
        chk("fin_finished0", finished0, 1);
        chk("fin_finished1", finished1, 1);
        chk("fin_valid", out_valid0, 0);
        chk("fin_busy", busy0, 1);
        chk("fin_core_reset", core_reset0, 1);
        chk("fin_addr", dm_addr0, 0);
        chk("fin_cycles", cycles0, n_run);
        chk("fin_timeout", timeout0, expect_tmo);
        next();
        #1;
        chk("post_finished", finished0, 0);
        chk("post_busy", busy0, 0);
        for (int j = 0; j < 2; j++) begin
            next();
            #1;
            chk("idle_no_restart", busy0, 0);
            chk("idle_no_finished", finished0, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b0;
        start = 1'b1;
        core_done = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) next();
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_core_reset", core_reset0, 1);
        chk("rst_valid", out_valid0, 0);
        chk("rst_finished", finished0, 0);
        chk("rst_addr1", dm_addr1, 0);
        chk("rst_cycles", cycles0, 0);
        chk("rst_timeout", timeout0, 0);

        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next();
            #1;
            chk("release_idle", busy0, 0);
            chk("release_core_reset", core_reset1, 1);
        end

        run(10, 0, -1, 1'b0, 1'b0);
        run(10, 1, -1, 1'b0, 1'b0);
        run(10, 0, 2, 1'b0, 1'b0);
        run(7, 1, -1, 1'b1, 1'b0);
`ifdef CORE_HOST_TIMEOUT_EN
        run(20, 0, -1, 1'b0, 1'b1);
        run(20, 0, -1, 1'b0, 1'b0);
`else
        run(1005, 0, -1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/core_host.md
CORE_HOST -- requirements
Module: core_host

Interface
REQ-001 Parameter BASE, default 8'h00: first data-memory address dumped after a run.
REQ-002 Parameter LEN, default 9'd64: number of bytes dumped, legal range 1..256.
REQ-003 Parameter TMO, default 16'd4096: maximum RUN cycles before abort; used only when the timeout feature is compiled in.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low; the block is in reset when reset==0 at a rising clk edge.
REQ-006 start  in  1  host request; sampled only in IDLE.
REQ-007 core_reset  out  1  active-high reset driven to the processor core.
REQ-008 core_done  in  1  processor done flag; sampled only in RUN.
REQ-009 dm_addr  out  8  data-memory read address.
REQ-010 dm_dat  in  8  data-memory read data, combinational (same-cycle) read.
REQ-011 out_dat  out  8  dump byte to host.
REQ-012 out_valid  out  1  out_dat valid.
REQ-013 out_ready  in  1  host accepts out_dat.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 cycles  out  16  RUN-cycle count of the last run.
REQ-016 timeout  out  1  last run aborted by timeout; sticky until the next run starts.
REQ-017 finished  out  1  one-cycle pulse on completion of a dump.

Function
REQ-018 The FSM SHALL have states IDLE, RSTC, RUN, DUMP and FIN.
- IDLE->RSTC on start==1.
- RSTC holds for exactly 2 cycles, then goes to RUN.
- RUN->DUMP on core_done==1.
- DUMP->FIN after the LEN-th accepted transfer.
- FIN->IDLE after 1 cycle.
REQ-019 core_reset SHALL be 0 only in RUN and 1 in every other state.
REQ-020 On RSTC entry, cycles SHALL clear to 0 and timeout SHALL clear to 0.
REQ-021 In RUN, cycles SHALL increment by 1 each cycle, including the cycle in which core_done is sampled high, and SHALL saturate at 16'hFFFF.
REQ-022 Outside RUN, cycles SHALL hold its value.
REQ-023 In DUMP, dm_addr SHALL equal (BASE + idx) mod 256, where idx counts accepted transfers starting from 0.
REQ-024 In DUMP, out_dat SHALL equal dm_dat in the same cycle.
REQ-025 out_valid SHALL be 1 in every DUMP cycle and 0 in every other state.
REQ-026 A transfer occurs when out_valid and out_ready are both 1; idx SHALL advance only on a transfer.
REQ-027 While out_ready==0, dm_addr and out_dat SHALL remain stable.
REQ-028 dm_addr SHALL wrap from 8'hFF to 8'h00 without error.
REQ-029 Outside DUMP, dm_addr SHALL be 0.
REQ-030 finished SHALL be 1 only in FIN.
REQ-031 start SHALL be ignored in every state except IDLE.
REQ-032 core_done SHALL be ignored in every state except RUN.
REQ-033 If the timeout abort (REQ-038) and core_done==1 occur in the same cycle, core_done SHALL win and timeout SHALL stay 0.

Reset
REQ-034 While reset==0, the block SHALL force state=IDLE, core_reset=1, out_valid=0, finished=0, busy=0, dm_addr=0, idx=0, cycles=0 and timeout=0.
REQ-035 Reset asserted in any state, including mid-RUN or mid-DUMP, SHALL abandon the operation at that edge with no further transfers.
REQ-036 The first state change after reset releases SHALL require start==1.

Configuration
REQ-037 Macro CORE_HOST_TIMEOUT_EN SHALL select the timeout behaviour.
REQ-038 With CORE_HOST_TIMEOUT_EN defined: in RUN, when cycles reaches TMO without core_done==1, the FSM SHALL go to DUMP on the next edge and set timeout=1.
REQ-039 Without CORE_HOST_TIMEOUT_EN: RUN SHALL wait for core_done indefinitely, timeout SHALL be tied to 0, and TMO SHALL be unused.

Verification
REQ-040 Nominal run: BASE=0, LEN=4, start pulse, core_done high on the 10th RUN cycle, out_ready=1 -> core_reset high 2 cycles, then low 10 cycles; cycles==10; bytes mem[0..3] delivered on 4 consecutive cycles; finished pulses once; busy falls the following cycle.
REQ-041 Backpressure: out_ready toggles 1,0,0,1,... -> no byte lost or duplicated; dm_addr and out_dat stable during stalls; exactly LEN transfers.
REQ-042 Wrap-around: BASE=8'hFE, LEN=4 -> dm_addr sequence FE, FF, 00, 01.
REQ-043 Reset mid-DUMP after 2 transfers: reset=0 for 1 cycle -> IDLE, out_valid=0, core_reset=1, cycles=0; no finished pulse.
REQ-044 Timeout (macro defined, TMO=20, core_done never asserted) -> DUMP entered after 20 RUN cycles with timeout=1. Without the macro -> RUN persists beyond 1000 cycles with timeout=0.
REQ-045 start held high during RUN and DUMP -> no restart; after FIN, a new run begins only if start==1 in IDLE.
